// File: rtl/frame_config_writer.sv
// -----------------------------------------------------------------------------
// frame_config_writer
//
// Purpose:
//   Turns a 32-bit configuration bitstream into frame writes for one tile
//   column. A packet is a sync word (0xFAB0_FAB1), then a header word, then
//   N frames of NumRows data words each. The header carries the frame count
//   N (bits [15:8]) and the start frame S (bits [4:0]). After the last row
//   of each frame arrives, the matching one-hot FrameStrobe bit is pulsed for
//   one cycle. Done pulses in the same cycle as the strobe of the last frame.
//
// Handshake:
//   A word moves on a rising edge where s_valid and s_ready are both high.
//   s_ready never depends on s_valid. It is low during reset, while MODE=0,
//   and in the strobe cycle. The source may hold s_valid low for any number
//   of cycles between words.
//
// Ports:
//   CLK          in   clock, rising edge
//   RESET        in   synchronous, active-high reset
//   MODE         in   1 = configuration, 0 = operation (aborts any packet)
//   s_data       in   [31:0] bitstream word
//   s_valid      in   s_data valid this cycle
//   s_ready      out  writer accepts s_data this cycle
//   FrameData    out  [FrameBitsPerRow*NumRows-1:0] frame rows, row r at
//                     [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  out  [MaxFramesPerCol-1:0] one-hot frame write strobe
//   Done         out  one-cycle pulse with the last strobe of a packet
//   Error        out  sticky bad-header flag, cleared by the next sync word
//   dbg_state_o  out  [1:0] FSM state (0 IDLE, 1 HEADER, 2 DATA, 3 STROBE)
// -----------------------------------------------------------------------------
module frame_config_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 2
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 MODE,
    input  logic [31:0]                          s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 Done,
    output logic                                 Error,
    output logic [1:0]                           dbg_state_o
);

    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
    localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } state_e;

    state_e                               state_q;
    logic [FW-1:0]                        frame_q;   // current frame index F
    logic [FW-1:0]                        last_q;    // final frame S+N-1
    logic [RW-1:0]                        row_q;     // next row to write R
    logic [FrameBitsPerRow*NumRows-1:0]   data_q;
    logic [MaxFramesPerCol-1:0]           strobe_q;
    logic                                 done_q;
    logic                                 error_q;

    logic       xfer;
    logic [7:0] hdr_n;
    logic [4:0] hdr_s;
    logic [8:0] hdr_end;
    logic [8:0] hdr_last;
    logic       hdr_ok;

    assign xfer = s_valid & s_ready;

    // Header decode. The 9-bit sum means S+N cannot wrap past the column size.
    assign hdr_n    = s_data[15:8];
    assign hdr_s    = s_data[4:0];
    assign hdr_end  = {1'b0, hdr_n} + {4'b0000, hdr_s};
    assign hdr_last = hdr_end - 9'd1;
    assign hdr_ok   = (hdr_n != 8'd0) && (hdr_end <= 9'(MaxFramesPerCol));

    // s_ready comes from reset, MODE and state only, never from s_valid.
    assign s_ready = !RESET && MODE && (state_q != STROBE);

    // MODE=0 blanks the pulse outputs at once. The registers clear on the next edge.
    assign FrameStrobe = MODE ? strobe_q : '0;
    assign Done        = MODE & done_q;
    assign FrameData   = data_q;
    assign Error       = error_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            last_q   <= '0;
            row_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else if (!MODE) begin
            // Abort the packet. Frame contents and the error flag are kept.
            state_q  <= IDLE;
            strobe_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer && (s_data == SyncWord)) begin
                        state_q <= HEADER;
                        error_q <= 1'b0;
                    end
                end

                HEADER: begin
                    if (xfer) begin
                        if (hdr_ok) begin
                            frame_q <= FW'(hdr_s);
                            last_q  <= FW'(hdr_last);
                            row_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        data_q[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow]
                            <= FrameBitsPerRow'(s_data);
                        if (row_q == RW'(NumRows - 1)) begin
                            // Set the strobe now so it is high in the very next cycle.
                            state_q  <= STROBE;
                            strobe_q <= StrobeOne << frame_q;
                            done_q   <= (frame_q == last_q);
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end

                STROBE: begin
                    strobe_q <= '0;
                    done_q   <= 1'b0;
                    // done_q is set only when this strobe is for the final frame.
                    if (done_q) begin
                        state_q <= IDLE;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                        row_q   <= '0;
                        state_q <= DATA;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_config_writer
//
// Runs frame_config_writer with its default parameters: 20 frames, two 32-bit
// rows per frame. The driver sends directed and random packets. For each
// frame it writes, it puts the expected strobe, frame data and Done value
// into a queue. A monitor checks each strobe or Done event the DUT shows
// against the head of that queue. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_config_writer;

    localparam int MAXF = 20;
    localparam int ROWS = 2;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    typedef struct packed {
        logic [MAXF-1:0]    strobe;
        logic [ROWS*32-1:0] data;
        logic               done;
    } ev_t;

    logic                 CLK;
    logic                 RESET;
    logic                 MODE;
    logic [31:0]          s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [ROWS*32-1:0]   FrameData;
    logic [MAXF-1:0]      FrameStrobe;
    logic                 Done;
    logic                 Error;
    logic [1:0]           dbg_state;

    ev_t                  exp_q[$];
    logic [ROWS*32-1:0]   m_frame;
    int                   n_checks;
    int                   n_pass;

    frame_config_writer #(
        .MaxFramesPerCol(MAXF),
        .FrameBitsPerRow(32),
        .NumRows(ROWS)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MODE(MODE),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .Done(Done),
        .Error(Error),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [MAXF-1:0] onehot(input int idx);
        logic [MAXF-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (!RESET && ((FrameStrobe != '0) || Done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {FrameStrobe, Done}, 96'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe", FrameStrobe, e.strobe);
                check("frame_data", FrameData, e.data);
                check("done", Done, e.done);
                check("ready_low_on_strobe", s_ready, 1'b0);
                check("strobe_onehot", $countones(FrameStrobe), 1);
            end
        end
    end

    // ---------------- driver ----------------
    // Call at a falling edge. Returns at the falling edge after the transfer,
    // plus gap idle cycles.
    task automatic send_word(input logic [31:0] w, input int gap);
        int budget;
        budget = 50;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (!s_ready) begin
            check("send_timeout", s_ready, 1'b1);
            s_valid = 1'b0;
            return;
        end
        @(negedge CLK);
        s_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    function automatic int pick_gap(input int gap_mode);
        return (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
    endfunction

    // Sends a full packet. Expected frame events come from the header rules.
    task automatic do_packet(input logic [31:0] hdr, input int gap_mode, input bit sync_data);
        int n;
        int s;
        bit ok;
        logic [31:0] w;
        n  = int'(hdr[15:8]);
        s  = int'(hdr[4:0]);
        ok = (n >= 1) && (s + n <= MAXF);
        send_word(SYNC, pick_gap(gap_mode));
        check("err_clear_on_sync", Error, 1'b0);
        send_word(hdr, pick_gap(gap_mode));
        if (!ok) begin
            check("err_bad_header", Error, 1'b1);
            return;
        end
        check("err_good_header", Error, 1'b0);
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < ROWS; r++) begin
                w = $urandom;
                if (sync_data && ($urandom_range(0, 3) == 0)) w = SYNC;
                m_frame[r*32 +: 32] = w;
                if (r == ROWS - 1) begin
                    exp_q.push_back('{strobe: onehot(s + k), data: m_frame, done: (k == n - 1)});
                    send_word(w, 0);
                    check("strobe_latency", FrameStrobe, onehot(s + k));
                    repeat (pick_gap(gap_mode)) @(negedge CLK);
                end else begin
                    send_word(w, pick_gap(gap_mode));
                end
            end
        end
    endtask

    task automatic send_garbage(input int count);
        logic [31:0] w;
        for (int i = 0; i < count; i++) begin
            w = $urandom;
            if (w == SYNC) w = w ^ 32'd1;
            send_word(w, int'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        n_checks = 0;
        n_pass   = 0;
        m_frame  = '0;
        RESET    = 1'b1;
        MODE     = 1'b1;
        s_valid  = 1'b1;   // reset must win over a pending word
        s_data   = SYNC;

        repeat (3) @(negedge CLK);
        check("reset_ready", s_ready, 1'b0);
        check("reset_strobe", FrameStrobe, '0);
        check("reset_done", Done, 1'b0);
        check("reset_error", Error, 1'b0);
        check("reset_data", FrameData, '0);
        RESET   = 1'b0;
        s_valid = 1'b0;
        @(negedge CLK);
        check("idle_ready", s_ready, 1'b1);

        // Basic single-frame packet into frame 3.
        do_packet(32'h0000_0103, 0, 1'b0);
        w0 = 32'h1111_1111;
        w1 = 32'h2222_2222;
        send_word(SYNC, 0);
        send_word(32'h0000_0103, 0);
        m_frame = {w1, w0};
        exp_q.push_back('{strobe: 20'h00008, data: 64'h2222_2222_1111_1111, done: 1'b1});
        send_word(w0, 0);
        send_word(w1, 0);
        check("basic_strobe", FrameStrobe, 20'h00008);
        check("basic_data", FrameData, 64'h2222_2222_1111_1111);

        // Three frames with s_valid toggling every other cycle.
        do_packet(32'h0000_0300, 1, 1'b0);

        // Headers that run past the column or have N=0, then the last frame slot.
        do_packet(32'h0000_0213, 0, 1'b0);
        do_packet(32'h0000_0000, 0, 1'b0);
        do_packet(32'h0000_0113, 0, 1'b0);
        do_packet(32'h0000_0014, 0, 1'b0);
        do_packet(32'h0000_1400, -1, 1'b0);
        // The sync word sent as a header is decoded as a header (N=0xFA).
        do_packet(SYNC, 0, 1'b0);

        // Drop MODE after the first row of a frame.
        send_word(SYNC, 0);
        send_word(32'h0000_0302, 0);
        w0 = $urandom;
        m_frame[31:0] = w0;
        send_word(w0, 0);
        MODE = 1'b0;
        #1;
        check("mode0_ready", s_ready, 1'b0);
        check("mode0_strobe", FrameStrobe, '0);
        repeat (3) @(negedge CLK);
        MODE = 1'b1;
        @(negedge CLK);
        send_word(32'h1234_5678, 0);
        send_garbage(3);
        check("retain_after_abort", FrameData, m_frame);
        check("error_kept_after_abort", Error, 1'b0);
        do_packet(32'h0000_0205, -1, 1'b1);

        // Random packets, some with junk before the sync word.
        for (int p = 0; p < 30; p++) begin
            logic [31:0] hdr;
            hdr = $urandom;
            hdr[15:8] = 8'($urandom_range(0, 8));
            hdr[4:0]  = 5'($urandom_range(0, 24));
            if ($urandom_range(0, 3) == 0) send_garbage(int'($urandom_range(1, 3)));
            do_packet(hdr, -1, 1'b1);
        end

        // Reset arrives during the strobe cycle.
        send_word(SYNC, 0);
        send_word(32'h0000_0105, 0);
        w0 = $urandom;
        w1 = $urandom;
        m_frame = {w1, w0};
        exp_q.push_back('{strobe: onehot(5), data: m_frame, done: 1'b1});
        send_word(w0, 0);
        send_word(w1, 0);
        #1;
        RESET = 1'b1;
        #1;
        check("ready_low_reset_strobe", s_ready, 1'b0);
        @(negedge CLK);
        m_frame = '0;
        check("reset_strobe_cleared", FrameStrobe, '0);
        check("reset_data_cleared", FrameData, m_frame);
        check("reset_error_cleared", Error, 1'b0);
        check("reset_done_cleared", Done, 1'b0);
        check("reset_ready_held", s_ready, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);
        do_packet(32'h0000_0400, -1, 1'b0);

        repeat (4) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_config_writer.md
FRAME_CONFIG_WRITER -- requirements
Module: frame_config_writer

Interface
REQ-001 Parameter MaxFramesPerCol, default 20, number of frame strobes driven per column.
REQ-002 Parameter FrameBitsPerRow, default 32, frame data bits per tile row; one input word = one row.
REQ-003 Parameter NumRows, default 2, rows (words) per frame.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  reset, synchronous to CLK and active-high.
REQ-006 MODE  input  1  global mode, 1 = configuration, 0 = operation.
REQ-007 s_data  input  32  bitstream word.
REQ-008 s_valid  input  1  s_data valid this cycle.
REQ-009 s_ready  output  1  writer accepts s_data this cycle; transfer = s_valid & s_ready.
REQ-010 FrameData  output  FrameBitsPerRow*NumRows  frame contents; row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
REQ-011 FrameStrobe  output  MaxFramesPerCol  one-hot write strobe into the tile column.
REQ-012 Done  output  1  one-cycle pulse, all frames of a packet written.
REQ-013 Error  output  1  sticky header-error flag.

Function
REQ-014 States SHALL be IDLE, HEADER, DATA, STROBE; no other state reachable.
REQ-015 IDLE: s_ready=1; transferred word equal to 0xFAB0_FAB1 -> HEADER and clear Error; any other word discarded, stay IDLE.
REQ-016 HEADER: s_ready=1; transferred word latched as header: count N = bits[15:8], start frame S = bits[4:0].
REQ-017 Header valid iff N>=1 and S+N<=MaxFramesPerCol (unsigned compare, 9-bit sum, no wrap); valid -> DATA with frame index F=S, row counter R=0.
REQ-018 Invalid header -> set Error, return to IDLE; no strobe asserted.
REQ-019 DATA: s_ready=1; each transfer writes s_data into FrameData row R, R increments; transfer with R=NumRows-1 -> STROBE.
REQ-020 STROBE: exactly one cycle; s_ready=0; FrameStrobe = one-hot bit F, all other bits 0; FrameData unchanged this cycle.
REQ-021 Leaving STROBE: if F = S+N-1 -> IDLE with Done=1 that same cycle; else F increments, R=0, -> DATA.
REQ-022 FrameStrobe SHALL be all-zero in every state other than STROBE; never more than one bit high.
REQ-023 FrameData SHALL hold its value between transfers; rows not written in the current frame retain previous values.
REQ-024 Strobe latency: FrameStrobe high in the cycle immediately after the transfer of the last row of a frame.
REQ-025 s_valid low in DATA: stall, no state change; gaps of any length permitted between words.
REQ-026 MODE=0: s_ready=0, FrameStrobe=0, state forced to IDLE next cycle from any state (abort mid-frame/mid-packet), Done not pulsed; Error retained.
REQ-027 Sync word received in DATA or HEADER SHALL be treated as data/header, not as resync.

Reset
REQ-028 RESET=1 at a rising edge: state=IDLE, FrameData=0, FrameStrobe=0, Done=0, Error=0, F=0, R=0.
REQ-029 s_ready SHALL be 0 during any cycle RESET=1; RESET overrides MODE and s_valid; reset mid-STROBE deasserts strobe next cycle.

Verification
REQ-030 MODE=1; words FAB0_FAB1, 0x0000_0103, 0x1111_1111, 0x2222_2222 -> FrameData=0x2222_2222_1111_1111, FrameStrobe=0x00008 for one cycle, Done pulse that same cycle.
REQ-031 Header 0x0000_0300, six data words, s_valid toggling every other cycle -> strobes bits 0,1,2 in order, one cycle each, s_ready=0 on each strobe cycle, single Done after bit 2.
REQ-032 Header 0x0000_0213 (S=19,N=2) -> Error=1, no strobe, state IDLE; next FAB0_FAB1 clears Error.
REQ-033 Header 0x0000_0000 (N=0) -> Error=1; header 0x0000_0113 (S=19,N=1) -> accepted, strobe bit 19.
REQ-034 MODE dropped after first data word of a frame -> no strobe, no Done, IDLE; MODE=1 then garbage 0x1234_5678 discarded until sync.
REQ-035 RESET asserted during STROBE -> next cycle FrameStrobe=0, FrameData=0, Error=0, s_ready=0 while RESET high.
